vram_tile_write_scheduler: RTL
==============================

VRAM_TILE_WRITE_SCHEDULER -- requirements
Module: vram_tile_write_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the tiles_written counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  host word valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-006 SHALL have port in_addr  input  15  host word address; [14:4] tile index, [3:0] word within tile.
REQ-007 SHALL have port in_data  input  16  host word data.
REQ-008 SHALL have port flush  input  1  discard the partially filled tile.
REQ-009 SHALL have port mem_write_enable  output  1  tile-memory write strobe.
REQ-010 SHALL have port mem_write_addr  output  15  tile-memory write address.
REQ-011 SHALL have port mem_write_data  output  16  tile-memory write data.
REQ-012 SHALL have port busy  output  1  high when the block is in BURST or holds a partial tile.
REQ-013 SHALL have port tiles_written  output  CNT_W  count of completed tile bursts.
REQ-014 SHALL have port seq_error  output  1  sticky error flag for misaligned or out-of-order words.

Function
REQ-015 SHALL use exactly two states, FILL and BURST; reset enters FILL.
REQ-016 A word SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 in FILL and 0 in BURST.
REQ-017 In FILL with fill count 0, an accepted word with in_addr[3:0]=0 SHALL be stored in staging slot 0, latch base=in_addr[14:4] and set fill count to 1.
REQ-018 In FILL with fill count 0, an accepted word with in_addr[3:0]!=0 SHALL be dropped, set seq_error and leave fill count at 0.
REQ-019 In FILL with fill count k (1..15), an accepted word with in_addr={base,k[3:0]} SHALL be stored in slot k and increment the count.
REQ-020 In FILL with fill count k (1..15), a mismatched accepted word SHALL set seq_error and discard slots 0..k-1; the word SHALL then be handled as in REQ-017/REQ-018.
REQ-021 Acceptance of the 16th word (count 15 -> 16) at edge T SHALL enter BURST at edge T, with the count cleared.
REQ-022 BURST SHALL drive mem_write_enable=1 for exactly 16 consecutive cycles. On burst cycle j (0..15): mem_write_addr={base,j[3:0]} and mem_write_data=slot j.
REQ-023 After the 16th burst cycle, BURST SHALL return to FILL. mem_write_enable SHALL be 0 for at least one cycle between bursts; the 16-word refill guarantees this, because tile memory resets its word counter only while the strobe is low.
REQ-024 mem_write_enable SHALL never drop inside a burst except on reset.
REQ-025 Outside BURST, mem_write_enable, mem_write_addr and mem_write_data SHALL be 0.
REQ-026 tiles_written SHALL increment by 1 on the edge ending the 16th burst cycle, and SHALL wrap modulo 2^CNT_W.
REQ-027 In FILL, flush=1 SHALL clear the fill count and discard staged words, with priority over a word accepted in the same cycle (that word is dropped); flush SHALL not set seq_error.
REQ-028 In BURST, flush SHALL be ignored.
REQ-029 busy SHALL be 1 in BURST or when fill count >0, and 0 otherwise.
REQ-030 seq_error SHALL stay set until reset.
REQ-031 Latency: 16th word accepted at edge T gives mem_write_enable=1 from T through T+16, with the first strobe edge at T+1 and the last at T+16.

Reset
REQ-032 With reset=1 at an edge, the block SHALL set state=FILL, fill count=0, mem_write_enable=0, mem_write_addr=0, mem_write_data=0, busy=0, tiles_written=0, seq_error=0; in_ready SHALL read 1 after that edge.
REQ-033 Reset asserted mid-BURST SHALL drop mem_write_enable at that edge, abandoning the burst; the tile memory discards its partial row, and no partial tile is counted.
REQ-034 Staging slot contents need not be cleared by reset.

Verification
REQ-035 Stream words addr 0x0120..0x012F, data 0xA000..0xA00F, in_valid held -> 16 strobe cycles, addr 0x0120..0x012F, data 0xA000..0xA00F in order, tiles_written=1, seq_error=0.
REQ-036 First word addr 0x0123 -> dropped, seq_error=1, busy=0, no strobe.
REQ-037 Words 0x0040..0x0044, then 0x0200..0x020F -> seq_error=1, one burst to 0x0200..0x020F only, tiles_written=1.
REQ-038 Words 0x0040..0x0047, flush=1, then 0x0050..0x005F -> one burst to 0x0050..0x005F, seq_error=0.
REQ-039 reset asserted on burst cycle 7 -> mem_write_enable=0 next cycle, tiles_written=0, in_ready=1.
REQ-040 2^CNT_W+1 full tiles with CNT_W=4 (17 tiles) -> tiles_written=1, with at least one strobe-low cycle between every pair of bursts; in_ready=0 throughout every burst.

Source files
------------

// File: rtl/vram_tile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vram_tile_write_scheduler
// Brief    : Collects 16 in-order host words of one tile into a staging
//            buffer, then writes the whole tile to tile memory as a single
//            uninterrupted 16-cycle strobe burst.
// Revision : 1.0 - initial release
// ============================================================================
module vram_tile_write_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      in_addr,
  input  logic [15:0]      in_data,
  input  logic             flush,
  output logic             mem_write_enable,
  output logic [14:0]      mem_write_addr,
  output logic [15:0]      mem_write_data,
  output logic             busy,
  output logic [CNT_W-1:0] tiles_written,
  output logic             seq_error
);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [3:0] c_last_word = 4'd15;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_fill_cnt;
  logic [3:0]  w_fill_cnt_next;
  logic [10:0] r_base;
  logic [10:0] w_base_next;
  logic [3:0]  r_burst_idx;
  logic [3:0]  w_burst_idx_next;
  logic        w_slot_we;
  logic [3:0]  w_slot_idx;
  logic        w_set_err;
  logic        w_tile_done;
  logic        w_accept;

  // Staging buffer; contents are only meaningful below the fill count,
  // so it carries no reset.
  logic [15:0] r_slot [16];

  // Next-state, staging control and all block outputs.
  always_comb begin
    w_state_next     = r_state;
    w_fill_cnt_next  = r_fill_cnt;
    w_base_next      = r_base;
    w_burst_idx_next = r_burst_idx;
    w_slot_we        = 1'b0;
    w_slot_idx       = 4'd0;
    w_set_err        = 1'b0;
    w_tile_done      = 1'b0;
    w_accept         = 1'b0;
    in_ready         = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_addr   = 15'd0;
    mem_write_data   = 16'd0;

    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (flush) begin
          // Flush wins over a word presented in the same cycle.
          w_fill_cnt_next = 4'd0;
        end else if (w_accept) begin
          if ((r_fill_cnt != 4'd0) && (in_addr == {r_base, r_fill_cnt})) begin
            w_slot_we  = 1'b1;
            w_slot_idx = r_fill_cnt;
            if (r_fill_cnt == c_last_word) begin
              w_state_next     = BURST;
              w_fill_cnt_next  = 4'd0;
              w_burst_idx_next = 4'd0;
            end else begin
              w_fill_cnt_next = r_fill_cnt + 4'd1;
            end
          end else begin
            // Out-of-order word: abandon the partial tile, then treat the
            // word as a potential start of a new tile.
            if (r_fill_cnt != 4'd0) begin
              w_set_err = 1'b1;
            end
            if (in_addr[3:0] == 4'd0) begin
              w_slot_we       = 1'b1;
              w_slot_idx      = 4'd0;
              w_base_next     = in_addr[14:4];
              w_fill_cnt_next = 4'd1;
            end else begin
              w_set_err       = 1'b1;
              w_fill_cnt_next = 4'd0;
            end
          end
        end
      end

      BURST: begin
        mem_write_enable = 1'b1;
        mem_write_addr   = {r_base, r_burst_idx};
        mem_write_data   = r_slot[r_burst_idx];
        w_burst_idx_next = r_burst_idx + 4'd1;
        if (r_burst_idx == c_last_word) begin
          w_state_next     = FILL;
          w_burst_idx_next = 4'd0;
          w_tile_done      = 1'b1;
        end
      end

      default: begin
        w_state_next = FILL;
      end
    endcase

    busy = (r_state == BURST) || (r_fill_cnt != 4'd0);
  end

  // State register plus counters and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FILL;
      r_fill_cnt    <= 4'd0;
      r_base        <= 11'd0;
      r_burst_idx   <= 4'd0;
      tiles_written <= '0;
      seq_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_fill_cnt  <= w_fill_cnt_next;
      r_base      <= w_base_next;
      r_burst_idx <= w_burst_idx_next;
      if (w_tile_done) begin
        tiles_written <= tiles_written + 1'b1;
      end
      if (w_set_err) begin
        seq_error <= 1'b1;
      end
    end
  end

  // Staging buffer write port.
  always_ff @(posedge clk) begin
    if (w_slot_we) begin
      r_slot[w_slot_idx] <= in_data;
    end
  end

endmodule
`default_nettype wire
